// File: rtl/free_list_obj_pkg.sv
// free_list_obj_pkg: shared rename constants, tag/pointer types and full detection
package free_list_obj_pkg;
    localparam int PHYS_REGS = 64;
    localparam int ARCH_REGS = 32;
    localparam int DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int TAG_W = $clog2(PHYS_REGS);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam string DBG_TAG = "FreeList";
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [PTR_W-1:0] ptr_t;
    // Full when the indices match but the wrap bits differ.
    function automatic logic is_full(input ptr_t tail, input ptr_t head);
        return (tail[IDX_W-1:0] == head[IDX_W-1:0]) && (tail[IDX_W] != head[IDX_W]);
    endfunction
endpackage

// File: rtl/free_list_obj_if.sv
// free_list_obj_if: dispatch/commit handshake between the pipeline and the free list
interface free_list_obj_if import free_list_obj_pkg::*; ();
    logic stall;
    logic alloc_req;
    tag_t alloc_tag;
    logic alloc_valid;
    logic free_en;
    tag_t free_tag;
    logic commit;
    logic flush;
    logic [TAG_W-1:0] free_count;
    logic err;
    modport master (
        output stall, alloc_req, free_en, free_tag, commit, flush,
        input  alloc_tag, alloc_valid, free_count, err
    );
    modport slave (
        input  stall, alloc_req, free_en, free_tag, commit, flush,
        output alloc_tag, alloc_valid, free_count, err
    );
endinterface

// File: rtl/free_list_obj_circ_ptr.sv
// free_list_obj_circ_ptr: wrap-aware FIFO pointer with increment and load
module free_list_obj_circ_ptr import free_list_obj_pkg::*; #(
    parameter ptr_t RST = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic load,
    input  ptr_t load_val,
    output ptr_t ptr
);
    // Load (flush recovery) takes priority over a normal advance.
    always_ff @(posedge clk)
        ptr <= reset ? RST : load ? load_val : ptr + ptr_t'(inc);
endmodule

// File: rtl/free_list_obj.sv
// free_list_obj: physical-register free list with speculative and committed heads
module free_list_obj import free_list_obj_pkg::*; (
    input logic clk,
    input logic reset,
    free_list_obj_if.slave fl
);
    tag_t mem [DEPTH];
    ptr_t spec_head, committed_head, tail, committed_next;
    logic empty, full, alloc_fire, free_hit, free_ok, commit_ok, commit_bad;
    // Gate each operation; commit is applied before a same-cycle flush reload.
    always_comb begin
        empty = spec_head == tail;
        full = is_full(tail, committed_head);
        alloc_fire = fl.alloc_req && !empty && !fl.stall && !fl.flush;
        free_hit = fl.free_en && (fl.free_tag != '0);
        free_ok = free_hit && !full;
        commit_bad = fl.commit && (committed_head == spec_head);
        commit_ok = fl.commit && !commit_bad;
        committed_next = committed_head + ptr_t'(commit_ok);
    end
    assign fl.alloc_tag = mem[spec_head[IDX_W-1:0]];
    assign fl.alloc_valid = !empty;
    assign fl.free_count = tail - spec_head;
    free_list_obj_circ_ptr #(.RST('0)) u_spec_head (
        .clk(clk), .reset(reset), .inc(alloc_fire), .load(fl.flush),
        .load_val(committed_next), .ptr(spec_head)
    );
    free_list_obj_circ_ptr #(.RST('0)) u_committed_head (
        .clk(clk), .reset(reset), .inc(commit_ok), .load(1'b0),
        .load_val('0), .ptr(committed_head)
    );
    free_list_obj_circ_ptr #(.RST(ptr_t'(DEPTH))) u_tail (
        .clk(clk), .reset(reset), .inc(free_ok), .load(1'b0),
        .load_val('0), .ptr(tail)
    );
    // Storage preloads the non-architectural tags and appends released tags at the tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= tag_t'(ARCH_REGS + i);
        end else if (free_ok) begin
            mem[tail[IDX_W-1:0]] <= fl.free_tag;
        end
    end
    // Sticky flag for a release into a full list or a commit with nothing outstanding.
    always_ff @(posedge clk)
        fl.err <= reset ? 1'b0 : fl.err | (free_hit && full) | commit_bad;
    // Pointer ordering: committed_head <= spec_head <= tail, occupancy never above DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (ptr_t'(spec_head - committed_head) <= ptr_t'(tail - committed_head));
            assert (ptr_t'(tail - committed_head) <= ptr_t'(DEPTH));
        end
    end
`ifdef FREELIST
    // Per-cycle trace of the pointers and occupancy.
    always_ff @(posedge clk)
        $display("%s spec_head=%0d committed_head=%0d tail=%0d free_count=%0d",
                 DBG_TAG, spec_head, committed_head, tail, fl.free_count);
`endif
endmodule

// File: tb/tb_free_list_obj.sv
// tb_free_list_obj: scoreboard-driven bench for the free list
module tb_free_list_obj;
    import free_list_obj_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    free_list_obj_if bus();
    free_list_obj dut (.clk(clk), .reset(reset), .fl(bus));
    int checks = 0;
    int failures = 0;
    int fl_q[$];
    int sp;
    bit m_err;
    int exp_q[$];
    int obs_q[$];

    task automatic clear_inputs();
        bus.alloc_req = 0; bus.free_en = 0; bus.free_tag = '0;
        bus.commit = 0; bus.flush = 0; bus.stall = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        fl_q.delete();
        for (int i = 0; i < DEPTH; i++) fl_q.push_back(ARCH_REGS + i);
        sp = 0;
        m_err = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic drive_cycle(input bit req, input bit fen, input int ftag,
                               input bit cmt, input bit flsh, input bit stl);
        int sp0;
        bit fire;
        bit full;
        bus.alloc_req = req; bus.free_en = fen; bus.free_tag = tag_t'(ftag);
        bus.commit = cmt; bus.flush = flsh; bus.stall = stl;
        #1;
        sp0 = sp;
        fire = req && (fl_q.size() > sp0) && !stl && !flsh;
        full = fl_q.size() == DEPTH;
        if (cmt && sp0 == 0) m_err = 1;
        if (fen && ftag != 0 && full) m_err = 1;
        if (fire) begin
            exp_q.push_back(fl_q[sp0]);
            obs_q.push_back(int'(bus.alloc_tag));
        end
        sp = sp0 + int'(fire);
        if (cmt && sp0 != 0) begin
            void'(fl_q.pop_front());
            sp--;
        end
        if (flsh) sp = 0;
        if (fen && ftag != 0 && !full) fl_q.push_back(ftag);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.alloc_tag !== 6'd32) begin failures++; $display("FAIL reset_tag got=%0d exp=32", bus.alloc_tag); end
        checks++; if (bus.alloc_valid !== 1'b1) begin failures++; $display("FAIL reset_valid got=%0b exp=1", bus.alloc_valid); end
        checks++; if (bus.free_count !== 6'd32) begin failures++; $display("FAIL reset_count got=%0d exp=32", bus.free_count); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
    endtask

    task automatic test_drain();
        int e, o;
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive_cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++; if (o !== e || o !== ARCH_REGS + i) begin failures++; $display("FAIL drain_tag[%0d] got=%0d exp=%0d", i, o, ARCH_REGS + i); end
        end
        checks++; if (bus.alloc_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0b exp=0", bus.alloc_valid); end
        checks++; if (bus.free_count !== 6'd0) begin failures++; $display("FAIL drain_count got=%0d exp=0", bus.free_count); end
        drive_cycle(1, 0, 0, 0, 0, 0);
        checks++; if (bus.free_count !== 6'd0 || bus.alloc_valid !== 1'b0) begin failures++; $display("FAIL extra_req count=%0d valid=%0b exp=0/0", bus.free_count, bus.alloc_valid); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL extra_req_err got=%0b exp=0", bus.err); end
    endtask

    task automatic test_free_empty();
        int e, o;
        for (int i = 0; i < DEPTH; i++) drive_cycle(0, 0, 0, 1, 0, 0);
        drive_cycle(0, 1, 5, 0, 0, 0);
        checks++; if (bus.alloc_tag !== 6'd5) begin failures++; $display("FAIL free_empty_tag got=%0d exp=5", bus.alloc_tag); end
        checks++; if (bus.alloc_valid !== 1'b1) begin failures++; $display("FAIL free_empty_valid got=%0b exp=1", bus.alloc_valid); end
        checks++; if (bus.free_count !== 6'd1) begin failures++; $display("FAIL free_empty_count got=%0d exp=1", bus.free_count); end
        drive_cycle(1, 1, 9, 0, 0, 0);
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        checks++; if (o !== e || o !== 5) begin failures++; $display("FAIL free_empty_alloc got=%0d exp=5", o); end
        checks++; if (bus.alloc_tag !== 6'd9 || bus.free_count !== 6'd1) begin failures++; $display("FAIL free_empty_next tag=%0d count=%0d exp=9/1", bus.alloc_tag, bus.free_count); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL free_empty_err got=%0b exp=0", bus.err); end
    endtask

    task automatic test_alloc_free();
        do_reset();
        repeat (22) drive_cycle(1, 0, 0, 0, 0, 0);
        repeat (22) drive_cycle(0, 0, 0, 1, 0, 0);
        exp_q.delete(); obs_q.delete();
        checks++; if (bus.free_count !== 6'd10) begin failures++; $display("FAIL af_pre_count got=%0d exp=10", bus.free_count); end
        drive_cycle(1, 1, 7, 0, 0, 0);
        checks++; if (bus.free_count !== 6'd10) begin failures++; $display("FAIL af_count got=%0d exp=10", bus.free_count); end
        checks++; if (obs_q.pop_front() !== 54) begin failures++; $display("FAIL af_tag exp=54"); end
        void'(exp_q.pop_front());
        checks++; if (bus.alloc_tag !== 6'd55 || bus.err !== 1'b0) begin failures++; $display("FAIL af_next tag=%0d err=%0b exp=55/0", bus.alloc_tag, bus.err); end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (4) drive_cycle(1, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 0, 0);
        drive_cycle(1, 0, 0, 0, 1, 0);
        checks++; if (bus.alloc_tag !== 6'd33) begin failures++; $display("FAIL flush_tag got=%0d exp=33", bus.alloc_tag); end
        checks++; if (bus.free_count !== 6'd31) begin failures++; $display("FAIL flush_count got=%0d exp=31", bus.free_count); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_commit_flush();
        do_reset();
        repeat (4) drive_cycle(1, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 1, 0);
        checks++; if (bus.alloc_tag !== 6'd33) begin failures++; $display("FAIL cflush_tag got=%0d exp=33", bus.alloc_tag); end
        checks++; if (bus.free_count !== 6'd31) begin failures++; $display("FAIL cflush_count got=%0d exp=31", bus.free_count); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_free_zero();
        drive_cycle(0, 1, 0, 0, 0, 0);
        checks++; if (bus.free_count !== 6'd31 || bus.alloc_tag !== 6'd33) begin failures++; $display("FAIL free_zero count=%0d tag=%0d exp=31/33", bus.free_count, bus.alloc_tag); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL free_zero_err got=%0b exp=0", bus.err); end
    endtask

    task automatic test_stall();
        do_reset();
        drive_cycle(1, 0, 0, 0, 0, 1);
        checks++; if (bus.free_count !== 6'd32 || bus.alloc_tag !== 6'd32) begin failures++; $display("FAIL stall count=%0d tag=%0d exp=32/32", bus.free_count, bus.alloc_tag); end
        drive_cycle(1, 0, 0, 0, 1, 0);
        checks++; if (bus.free_count !== 6'd32 || bus.alloc_tag !== 6'd32) begin failures++; $display("FAIL flush_alloc count=%0d tag=%0d exp=32/32", bus.free_count, bus.alloc_tag); end
    endtask

    task automatic test_free_full();
        do_reset();
        drive_cycle(0, 1, 9, 0, 0, 0);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL free_full_err got=%0b exp=1", bus.err); end
        checks++; if (bus.free_count !== 6'd32 || bus.alloc_tag !== 6'd32) begin failures++; $display("FAIL free_full count=%0d tag=%0d exp=32/32", bus.free_count, bus.alloc_tag); end
    endtask

    task automatic test_commit_empty();
        do_reset();
        drive_cycle(0, 0, 0, 1, 0, 0);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL commit_empty_err got=%0b exp=1", bus.err); end
        checks++; if (bus.free_count !== 6'd32) begin failures++; $display("FAIL commit_empty_count got=%0d exp=32", bus.free_count); end
    endtask

    task automatic test_random();
        int e, o;
        bit cmt;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            cmt = (sp > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
            drive_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 63),
                        cmt, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
            checks++; if (int'(bus.free_count) !== fl_q.size() - sp) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, bus.free_count, fl_q.size() - sp); end
            checks++; if (bus.alloc_valid !== (fl_q.size() > sp)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b", c, bus.alloc_valid); end
            checks++; if (bus.err !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", c, bus.err, m_err); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++; if (o !== e) begin failures++; $display("FAIL rnd_tag cyc=%0d got=%0d exp=%0d", c, o, e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_cycle(0, 0, 0, 1, 0, 0);
        repeat (5) drive_cycle(1, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 1, 0, 0);
        drive_cycle(0, 1, 12, 0, 0, 0);
        do_reset();
        checks++; if (bus.alloc_tag !== 6'd32) begin failures++; $display("FAIL mid_reset_tag got=%0d exp=32", bus.alloc_tag); end
        checks++; if (bus.alloc_valid !== 1'b1) begin failures++; $display("FAIL mid_reset_valid got=%0b exp=1", bus.alloc_valid); end
        checks++; if (bus.free_count !== 6'd32) begin failures++; $display("FAIL mid_reset_count got=%0d exp=32", bus.free_count); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL mid_reset_err got=%0b exp=0", bus.err); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_drain();
        test_free_empty();
        test_alloc_free();
        test_flush();
        test_commit_flush();
        test_free_zero();
        test_stall();
        test_free_full();
        test_commit_empty();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/free_list_obj.md
Name: free_list_obj

Overview:
- Physical-register free list feeding the rename table.
- Supplies a fresh physical tag for each renamed destination at dispatch.
- Receives previously-mapped tags released at commit.
- On branch-mispredict flush, restores itself to the committed state in one cycle.
- Organisation: circular FIFO of tags with three pointers: speculative head, committed head, tail.

Parameters:
- PHYS_REGS, 64, number of physical registers; tag width = clog2(PHYS_REGS) = 6
- ARCH_REGS, 32, architectural registers; tags 0..ARCH_REGS-1 are architecturally mapped at reset
- DEPTH, PHYS_REGS-ARCH_REGS = 32, FIFO capacity
- tag, "FreeList", debug display string

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- stall  in  1  freezes allocation only
- alloc_req  in  1  dispatch wants a new tag this cycle
- alloc_tag  out  6  tag at speculative head (show-ahead, combinational from storage)
- alloc_valid  out  1  list non-empty; alloc_tag is meaningful
- free_en  in  1  commit releases a tag (from table's returned_mapping/return_map)
- free_tag  in  6  tag being released
- commit  in  1  an instruction holding an allocated tag retires
- flush  in  1  mispredict recovery
- free_count  out  6  entries between speculative head and tail (0..32)
- err  out  1  sticky protocol-violation flag

Behaviour:
- Pointers are 6 bits: 5-bit index plus wrap bit.
  - Empty when spec_head == tail.
  - Full when tail - committed_head == DEPTH (index equal, wrap bits differ).
- Reset (sync, when reset=1 at posedge):
  - storage[i] = ARCH_REGS+i for i = 0..31.
  - spec_head = committed_head = 0; tail = 32 (wrap bit set).
  - err = 0.
  - Outputs after reset: alloc_tag = 32, alloc_valid = 1, free_count = 32.
  - Reset overrides every other input; asserting reset mid-operation discards all in-flight state.
- Allocation:
  - Fires when alloc_req && alloc_valid && !stall && !flush.
  - spec_head advances by 1 at posedge; the tag is consumed that cycle.
  - Zero-latency: tag is visible before the request.
  - alloc_req while empty: no pop; not an error. Dispatch must stall.
- Free:
  - free_en with free_tag != 0 writes storage[tail] and advances tail.
  - free_tag == 0 is ignored. Register 0 is never remapped.
  - free_en while full: ignored, err set.
  - Free is never gated by stall or flush; frees are non-speculative.
- Commit:
  - Advances committed_head by 1.
  - Commit when committed_head == spec_head: ignored, err set.
  - Not gated by stall.
- Flush: spec_head <= committed_head after that cycle's commit is applied. Same-cycle commit is counted first.
- Same-cycle combinations:
  - Alloc + free: both apply; free_count unchanged.
  - Alloc + free when empty: no alloc; the freed tag is available next cycle. There is no bypass.
  - Flush + alloc: flush wins; no pop.
- free_count = tail - spec_head (6-bit modular), registered-pointer based, valid every cycle.
- Invariants (for assertions):
  - committed_head <= spec_head <= tail in modular order.
  - tail - committed_head <= DEPTH.
- Debug: under `ifdef FREELIST, display tag, the three pointers and free_count each cycle.

Decomposition:
- Shared package/config: TAG_W = 6, PHYS_REGS, ARCH_REGS. Rename table and ROB use the same constants.
- Sub-module circ_ptr: 6-bit wrap-aware pointer with inc and load inputs. Instantiated three times; spec_head uses load for flush.
- Storage stays inline: a 32x6 register array.

Test Plan:
- Reset, no traffic -> alloc_tag = 32, alloc_valid = 1, free_count = 32, err = 0.
- 32 consecutive allocs -> tags 32..63 in order; then alloc_valid = 0, free_count = 0.
- A 33rd request produces no pop.
- From empty: free_tag = 5 -> next cycle alloc_tag = 5, alloc_valid = 1.
- Same-cycle alloc + free_tag = 7 with count 10 -> count stays 10.
- Alloc 4 (32..35), commit 1, flush -> alloc_tag = 33, free_count = 31.
- Same-cycle commit + flush after 4 allocs -> next alloc_tag = 33.
- free_tag = 0 -> no change.
- free while full (just after reset) -> err = 1, count stays 32.
- Commit with no outstanding alloc -> err = 1.
- Reset mid-stream -> state returns to the reset values above.
